// File: rtl/rob_alloc_ctrl.sv
// ROB allocation controller: grants up to two in-order dispatch slots per cycle,
// owns the enqueue/dequeue pointers and occupancy, and rolls back on redirect flush.
module rob_alloc_ctrl #(
  parameter int ROB_SIZE_LOG = 6,
  parameter int CMT_WIDTH    = 2
) (
  input  logic                    clock,
  input  logic                    reset_n,
  input  logic                    instr0_valid,
  output logic                    instr0_ready,
  input  logic                    instr1_valid,
  output logic                    instr1_ready,
  input  logic                    to_issue_instr0_ready,
  input  logic                    to_issue_instr1_ready,
  output logic                    to_issue_instr0_valid,
  output logic                    to_issue_instr1_valid,
  output logic                    to_issue_instr0_robidx_flag,
  output logic [ROB_SIZE_LOG-1:0] to_issue_instr0_robidx,
  output logic                    to_issue_instr1_robidx_flag,
  output logic [ROB_SIZE_LOG-1:0] to_issue_instr1_robidx,
  input  logic [1:0]              commit_cnt,
  input  logic                    flush_valid,
  input  logic                    flush_robidx_flag,
  input  logic [ROB_SIZE_LOG-1:0] flush_robidx,
  output logic                    enq_robidx_flag,
  output logic [ROB_SIZE_LOG-1:0] enq_robidx,
  output logic                    deq_robidx_flag,
  output logic [ROB_SIZE_LOG-1:0] deq_robidx,
  output logic [ROB_SIZE_LOG:0]   counter,
  output logic                    rob_full,
  output logic                    rob_empty
);

  localparam int PW = ROB_SIZE_LOG + 1;
  localparam logic [PW-1:0] ROB_SIZE_P = PW'(1 << ROB_SIZE_LOG);

  logic [PW-1:0] enq_ptr_q, deq_ptr_q, cnt_q;
  logic [PW-1:0] enq_ptr_d, deq_ptr_d, cnt_d;
  logic [PW-1:0] free, enq_ptr_p1, flush_ptr, flush_dist;
  logic [PW-1:0] fire_sum, commit_ext;
  logic          fire0, fire1;
  logic          room_one, room_two;

  // Free space uses the registered counter only: same-cycle commits never open room.
  assign free     = ROB_SIZE_P - cnt_q;
  assign room_one = (free >= PW'(1));
  assign room_two = (free >= PW'(2));

  assign instr0_ready = reset_n & ~flush_valid & room_one & to_issue_instr0_ready;
  assign fire0        = instr0_valid & instr0_ready;
  assign instr1_ready = reset_n & ~flush_valid & fire0 & room_two & to_issue_instr1_ready;
  assign fire1        = instr1_valid & instr1_ready;

  assign to_issue_instr0_valid = fire0;
  assign to_issue_instr1_valid = fire1;

  // Pointer arithmetic wraps modulo 2*ROB_SIZE so the flag toggles on index wrap.
  assign enq_ptr_p1 = enq_ptr_q + PW'(1);

  assign {to_issue_instr0_robidx_flag, to_issue_instr0_robidx} = enq_ptr_q;
  assign {to_issue_instr1_robidx_flag, to_issue_instr1_robidx} = enq_ptr_p1;

  assign flush_ptr  = {flush_robidx_flag, flush_robidx};
  assign flush_dist = flush_ptr - deq_ptr_q;
  assign fire_sum   = PW'(fire0) + PW'(fire1);
  assign commit_ext = PW'(commit_cnt);

  always_comb begin
    deq_ptr_d = deq_ptr_q + commit_ext;
    enq_ptr_d = enq_ptr_q + fire_sum;
    cnt_d     = cnt_q + fire_sum - commit_ext;
    if (flush_valid) begin
      // The flushing instruction survives, so allocation resumes right after it.
      enq_ptr_d = flush_ptr + PW'(1);
      cnt_d     = enq_ptr_d - deq_ptr_d;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      enq_ptr_q <= '0;
      deq_ptr_q <= '0;
      cnt_q     <= '0;
    end else begin
      enq_ptr_q <= enq_ptr_d;
      deq_ptr_q <= deq_ptr_d;
      cnt_q     <= cnt_d;
    end
  end

  assign {enq_robidx_flag, enq_robidx} = enq_ptr_q;
  assign {deq_robidx_flag, deq_robidx} = deq_ptr_q;
  assign counter   = cnt_q;
  assign rob_full  = (cnt_q == ROB_SIZE_P);
  assign rob_empty = (cnt_q == '0);

  a_commit_le_count: assert property (@(posedge clock) disable iff (!reset_n)
    commit_ext <= cnt_q);

  a_commit_le_width: assert property (@(posedge clock) disable iff (!reset_n)
    commit_ext <= PW'(CMT_WIDTH));

  a_flush_in_window: assert property (@(posedge clock) disable iff (!reset_n)
    flush_valid |-> (flush_dist < cnt_q));

  a_count_bounded: assert property (@(posedge clock) disable iff (!reset_n)
    cnt_q <= ROB_SIZE_P);

  a_in_order_fire: assert property (@(posedge clock) disable iff (!reset_n)
    fire1 |-> fire0);

endmodule
